// File: rtl/alu_pkg.sv
// Shared definitions for the registered 8-bit ALU: default datapath width and opcode encoding.
package alu_pkg;

    localparam int ALU_WIDTH = 8;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_SHL  = 3'b101,
        OP_SHR  = 3'b110,
        OP_PASS = 3'b111
    } alu_op_e;

endpackage

// File: rtl/alu_addsub.sv
// Shared adder/subtractor: computes a + (b ^ {sub}) + sub in one WIDTH+1 adder.
// Signed-overflow output exists only when ALU_STATUS_FLAGS_EN is defined.
module alu_addsub #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry
`ifdef ALU_STATUS_FLAGS_EN
    ,
    output logic             overflow
`endif
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   total;

    assign b_eff = b ^ {WIDTH{sub}};
    assign total = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    assign sum   = total[WIDTH-1:0];

    // Carry-out of a two's-complement subtract means "no borrow"; invert it to report borrow.
    assign carry = total[WIDTH] ^ sub;

`ifdef ALU_STATUS_FLAGS_EN
    assign overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
`endif

endmodule

// File: rtl/alu_8bit.sv
// Registered 8-bit ALU: opcode mux over shared add/sub, logic and shift ops, one-cycle latency.
// Define ALU_STATUS_FLAGS_EN to add registered zero/negative/overflow outputs.
module alu_8bit
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       opcode,
    output logic             valid_out,
    output logic [WIDTH-1:0] result,
    output logic             carry
`ifdef ALU_STATUS_FLAGS_EN
    ,
    output logic             zero,
    output logic             negative,
    output logic             overflow
`endif
);

    alu_op_e          op;
    logic             is_sub;
    logic [WIDTH-1:0] as_sum;
    logic             as_carry;
    logic [WIDTH-1:0] res_nxt;
    logic             carry_nxt;

    assign op     = alu_op_e'(opcode);
    assign is_sub = (op == OP_SUB);

`ifdef ALU_STATUS_FLAGS_EN
    logic as_ovf;
    logic ovf_nxt;
`endif

    alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a       (A),
        .b       (B),
        .sub     (is_sub),
        .sum     (as_sum),
        .carry   (as_carry)
`ifdef ALU_STATUS_FLAGS_EN
        ,
        .overflow(as_ovf)
`endif
    );

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        res_nxt   = A;
        carry_nxt = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                res_nxt   = as_sum;
                carry_nxt = as_carry;
            end
            OP_AND:  res_nxt = A & B;
            OP_OR:   res_nxt = A | B;
            OP_XOR:  res_nxt = A ^ B;
            OP_SHL: begin
                res_nxt   = {A[WIDTH-2:0], 1'b0};
                carry_nxt = A[WIDTH-1];
            end
            OP_SHR: begin
                res_nxt   = {1'b0, A[WIDTH-1:1]};
                carry_nxt = A[0];
            end
            OP_PASS: res_nxt = A;
            default: res_nxt = A;
        endcase
    end

`ifdef ALU_STATUS_FLAGS_EN
    assign ovf_nxt = is_sub || (op == OP_ADD) ? as_ovf : 1'b0;
`endif

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments; reset wins over a same-cycle issue.
        if (rst) begin
            valid_out <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
`ifdef ALU_STATUS_FLAGS_EN
            zero      <= 1'b0;
            negative  <= 1'b0;
            overflow  <= 1'b0;
`endif
        end else begin
            valid_out <= valid_in;
            if (valid_in) begin
                result    <= res_nxt;
                carry     <= carry_nxt;
`ifdef ALU_STATUS_FLAGS_EN
                zero      <= (res_nxt == '0);
                negative  <= res_nxt[WIDTH-1];
                overflow  <= ovf_nxt;
`endif
            end
        end
    end

endmodule

// File: tb/tb_alu_8bit.sv
// Scoreboard bench for alu_8bit: driver pushes reference-model expectations, monitor pops and compares.
// Flag outputs are also checked when ALU_STATUS_FLAGS_EN is defined.
module tb_alu_8bit;
    import alu_pkg::*;

    typedef struct {
        logic       vout;
        logic [7:0] res;
        logic       car;
        logic       z;
        logic       n;
        logic       o;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       valid_in;
    logic [7:0] A;
    logic [7:0] B;
    logic [2:0] opcode;
    logic       valid_out;
    logic [7:0] result;
    logic       carry;
`ifdef ALU_STATUS_FLAGS_EN
    logic       zero;
    logic       negative;
    logic       overflow;
`endif

    exp_t exp_q[$];
    exp_t mdl;
    int   checks   = 0;
    int   failures = 0;

    alu_8bit dut (
        .clk      (clk),
        .rst      (rst),
        .valid_in (valid_in),
        .A        (A),
        .B        (B),
        .opcode   (opcode),
        .valid_out(valid_out),
        .result   (result),
        .carry    (carry)
`ifdef ALU_STATUS_FLAGS_EN
        ,
        .zero     (zero),
        .negative (negative),
        .overflow (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, got, want);
        end
    endtask

    // Reference model in plain integer arithmetic on unsigned/signed interpretations.
    task automatic model_op(input alu_op_e op, input int a, input int b, output exp_t e);
        int r;
        int sa;
        int sb;
        int sr;
        e.vout = 1'b1;
        e.o    = 1'b0;
        e.car  = 1'b0;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        case (op)
            OP_ADD: begin
                r     = a + b;
                e.car = (r > 255);
                sr    = sa + sb;
                e.o   = (sr > 127) || (sr < -128);
            end
            OP_SUB: begin
                r     = a - b + 256;
                e.car = (a < b);
                sr    = sa - sb;
                e.o   = (sr > 127) || (sr < -128);
            end
            OP_AND: r = int'(8'(a) & 8'(b));
            OP_OR:  r = int'(8'(a) | 8'(b));
            OP_XOR: r = int'(8'(a) ^ 8'(b));
            OP_SHL: begin
                r     = a * 2;
                e.car = (a >= 128);
            end
            OP_SHR: begin
                r     = a / 2;
                e.car = (a % 2) == 1;
            end
            default: r = a;
        endcase
        r     = r % 256;
        e.res = 8'(r);
        e.z   = (r == 0);
        e.n   = (r >= 128);
    endtask

    task automatic issue(input logic r, input logic v, input alu_op_e op, input logic [7:0] a,
                         input logic [7:0] b);
        exp_t e;
        rst      = r;
        valid_in = v;
        opcode   = op;
        A        = a;
        B        = b;
        if (r) begin
            mdl = '{vout: 1'b0, res: 8'h00, car: 1'b0, z: 1'b0, n: 1'b0, o: 1'b0};
        end else if (v) begin
            model_op(op, int'(a), int'(b), e);
            mdl = e;
        end else begin
            mdl.vout = 1'b0;
        end
        exp_q.push_back(mdl);
        @(negedge clk);
    endtask

    function automatic logic [7:0] pick_operand();
        logic [7:0] corners [5];
        corners = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        return 8'($urandom);
    endfunction

    // Monitor: one expectation per clock, compared 1 time unit after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard at %0t: DUT cycle with no expectation queued", $time);
            end else begin
                e = exp_q.pop_front();
                check("valid_out", 32'(valid_out), 32'(e.vout));
                check("result", 32'(result), 32'(e.res));
                check("carry", 32'(carry), 32'(e.car));
`ifdef ALU_STATUS_FLAGS_EN
                check("zero", 32'(zero), 32'(e.z));
                check("negative", 32'(negative), 32'(e.n));
                check("overflow", 32'(overflow), 32'(e.o));
`endif
            end
        end
    end

    initial begin
        rst      = 1'b1;
        valid_in = 1'b0;
        A        = '0;
        B        = '0;
        opcode   = '0;
        mdl      = '{vout: 1'b0, res: 8'h00, car: 1'b0, z: 1'b0, n: 1'b0, o: 1'b0};

        issue(1'b1, 1'b0, OP_ADD, 8'd0, 8'd0);
        issue(1'b1, 1'b0, OP_ADD, 8'd0, 8'd0);

        issue(1'b0, 1'b1, OP_ADD, 8'd10, 8'd5);
        issue(1'b0, 1'b1, OP_SUB, 8'd10, 8'd3);
        issue(1'b0, 1'b1, OP_SUB, 8'd3, 8'd10);
        issue(1'b0, 1'b1, OP_AND, 8'h0C, 8'h0A);
        issue(1'b0, 1'b1, OP_OR, 8'h0C, 8'h0A);
        issue(1'b0, 1'b1, OP_XOR, 8'h0C, 8'h0A);
        issue(1'b0, 1'b1, OP_ADD, 8'd255, 8'd1);
        issue(1'b0, 1'b1, OP_SUB, 8'd0, 8'd1);
        issue(1'b0, 1'b1, OP_SHL, 8'h81, 8'h00);
        issue(1'b0, 1'b1, OP_SHR, 8'h81, 8'h00);
        issue(1'b0, 1'b1, OP_PASS, 8'hA5, 8'h3C);
        issue(1'b1, 1'b1, OP_ADD, 8'd10, 8'd5);
        issue(1'b0, 1'b1, OP_ADD, 8'd10, 8'd5);
        issue(1'b0, 1'b0, OP_SUB, 8'd1, 8'd9);
        issue(1'b0, 1'b0, OP_XOR, 8'hFF, 8'h00);
        issue(1'b0, 1'b1, OP_ADD, 8'h7F, 8'h01);
        issue(1'b0, 1'b1, OP_SUB, 8'h80, 8'h01);
        issue(1'b0, 1'b1, OP_ADD, 8'h00, 8'h00);

        for (int i = 0; i < 400; i++) begin
            issue($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
                  alu_op_e'($urandom_range(0, 7)), pick_operand(), pick_operand());
        end

        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
